// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Front-end fetch controller. Issues I-cache line requests starting at
// BOOT_ADDR (or a redirect target), remembers the fetch address of every
// in-flight request, and forwards each returned line together with its fetch
// address to the instruction re-aligner. A downstream credit budget ensures
// every returned line has a slot. After a redirect, responses still in flight
// are silently dropped.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             redirect strobe, kills all in-flight fetches
//   redirect_addr_i     new fetch address, sampled while flush_i=1
//   halt_i              stop issuing new requests (level)
//   req_valid_o/req_ready_i/req_addr_o   cache request channel
//   resp_valid_i/resp_data_i             cache response (in order, no stall)
//   credit_return_i     downstream freed one line slot (pulse)
//   realign_valid_o/realign_addr_o/realign_data_o  line to re-aligner
//   realign_flush_o     flush to re-aligner
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int          FETCH_WIDTH     = 32,
  parameter logic [63:0] BOOT_ADDR       = 64'h8000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          CREDITS         = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [63:0]            redirect_addr_i,
  input  logic                   halt_i,
  output logic                   req_valid_o,
  input  logic                   req_ready_i,
  output logic [63:0]            req_addr_o,
  input  logic                   resp_valid_i,
  input  logic [FETCH_WIDTH-1:0] resp_data_i,
  input  logic                   credit_return_i,
  output logic                   realign_valid_o,
  output logic [63:0]            realign_addr_o,
  output logic [FETCH_WIDTH-1:0] realign_data_o,
  output logic                   realign_flush_o
);

  localparam int FETCH_BYTES = FETCH_WIDTH / 8;
  localparam int CNT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CRED_W      = $clog2(CREDITS + 1);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HALTED
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        npc_q;
  logic [CNT_W-1:0]   count_q;     // outstanding requests = FIFO occupancy
  logic [CNT_W-1:0]   drop_cnt_q;  // stale responses still to be discarded
  logic [CRED_W-1:0]  credits_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]        addr_mem [MAX_OUTSTANDING];

  logic               handshake;
  logic               resp_accept;
  logic               resp_drop;
  logic [CRED_W:0]    cred_sum;
  logic [CRED_W-1:0]  credits_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Request side: registered counts only, so a request once raised can only
  // be withdrawn by a flush (counts can only move in its favour meanwhile).
  assign req_valid_o = (state_q == ST_RUN) && !flush_i &&
                       (count_q < CNT_W'(MAX_OUTSTANDING)) && (credits_q != '0);
  assign req_addr_o  = npc_q;
  assign handshake   = req_valid_o && req_ready_i;

  // A response with nothing outstanding is spurious and changes nothing.
  assign resp_accept = resp_valid_i && (count_q != '0);
  assign resp_drop   = resp_accept && ((drop_cnt_q != '0) || flush_i);

  assign realign_valid_o = resp_accept && !resp_drop;
  assign realign_addr_o  = realign_valid_o ? addr_mem[rd_ptr_q] : 64'h0;
  assign realign_data_o  = realign_valid_o ? resp_data_i : '0;
  assign realign_flush_o = flush_i;

  // NOTE: every signal assigned in always_comb gets a default first so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (halt_i && (!req_valid_o || handshake)) state_d = ST_HALTED;
      ST_HALTED: if (!halt_i || flush_i) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Credits: all same-cycle events sum, then saturate at the reset budget.
  always_comb begin
    cred_sum = {1'b0, credits_q}
             - (CRED_W+1)'(handshake)
             + (CRED_W+1)'(credit_return_i)
             + (CRED_W+1)'(resp_drop);
    credits_d = credits_q;
    if (cred_sum > (CRED_W+1)'(CREDITS)) credits_d = CRED_W'(CREDITS);
    else                                 credits_d = cred_sum[CRED_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so that all
  // registers update together from the pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_BOOT;
      npc_q      <= BOOT_ADDR;
      count_q    <= '0;
      drop_cnt_q <= '0;
      credits_q  <= CRED_W'(CREDITS);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      count_q   <= count_q + CNT_W'(handshake) - CNT_W'(resp_accept);

      if (flush_i)        npc_q <= redirect_addr_i;
      else if (handshake) npc_q <= (npc_q & ~64'(FETCH_BYTES - 1)) + 64'(FETCH_BYTES);

      // Everything still in flight after this cycle is stale.
      if (flush_i)                           drop_cnt_q <= count_q - CNT_W'(resp_accept);
      else if (resp_drop && drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - CNT_W'(1);

      if (handshake)   wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (resp_accept) rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // NOTE: the address storage is not reset; entries are only read while
  // occupied and the re-aligner outputs are gated to zero otherwise.
  always_ff @(posedge clk_i) begin
    if (handshake) addr_mem[wr_ptr_q] <= npc_q;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end fetch controller that sequences I-cache line requests and feeds returned lines, with their fetch addresses, to the instruction re-aligner. It tracks in-flight requests, enforces a downstream credit budget so every returned line has a guaranteed slot, and kills stale responses after a redirect. It sits between the PC/redirect logic, the I-cache port and the re-aligner/instruction queue.

## Interface
- FETCH_WIDTH, 32: bits per fetch line (32 or 64); FETCH_BYTES = FETCH_WIDTH/8.
- BOOT_ADDR, 64'h8000_0000: first fetch address after reset.
- MAX_OUTSTANDING, 2: maximum un-responded cache requests (1..4).
- CREDITS, 4: downstream line slots available at reset.
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  redirect strobe; kills all in-flight fetches.
- redirect_addr_i  in  64  new fetch address, sampled when flush_i=1.
- halt_i  in  1  stop issuing new requests (level).
- req_valid_o  out  1  cache request valid.
- req_ready_i  in  1  cache accepts request.
- req_addr_o  out  64  request address.
- resp_valid_i  in  1  cache returns one line, in request order, cannot be stalled.
- resp_data_i  in  FETCH_WIDTH  line data.
- credit_return_i  in  1  downstream freed one line slot (pulse).
- realign_valid_o  out  1  line valid to re-aligner.
- realign_addr_o  out  64  fetch address of that line.
- realign_data_o  out  FETCH_WIDTH  line data.
- realign_flush_o  out  1  flush to re-aligner.

## Operation
- FSM: BOOT -> RUN -> HALTED.
  - BOOT: entered on reset; req_valid_o=0; next cycle -> RUN.
  - RUN -> HALTED when halt_i=1 and no request is pending (req_valid_o=0, or handshake this cycle).
  - HALTED -> RUN when halt_i=0 or flush_i=1.
- npc register: reset BOOT_ADDR. req_addr_o = npc. On handshake (req_valid_o & req_ready_i): npc <= (npc & ~(FETCH_BYTES-1)) + FETCH_BYTES. First fetch after reset/redirect may be halfword-unaligned; subsequent fetches are line-aligned.
- req_valid_o = state==RUN & !flush_i & outstanding_q<MAX_OUTSTANDING & credits_q>0 (registered counts only, no same-cycle bypass). Once asserted, req_valid_o and req_addr_o hold until handshake, except a flush withdraws the request.
- Address FIFO, depth MAX_OUTSTANDING: push npc on handshake, pop on resp_valid_i. outstanding_q = occupancy.
- credits_q: reset CREDITS; -1 on handshake; +1 on credit_return_i; +1 on every dropped response; simultaneous events sum. Saturates at CREDITS (extra returns ignored).
- drop_cnt_q: reset 0. Response with drop_cnt_q>0 or flush_i=1 is dropped (realign_valid_o=0), drop_cnt decrements if >0.
- Non-dropped response: realign_valid_o=1, realign_addr_o=FIFO head, realign_data_o=resp_data_i.
- flush_i: npc <= redirect_addr_i; drop_cnt <= outstanding_q - resp_valid_i (every request still in flight after this cycle is stale); realign_flush_o=flush_i; no handshake in this cycle.
- resp_valid_i with outstanding_q==0: ignored, no counter change.

## Timing
- Reset values: req_valid_o=0, req_addr_o=BOOT_ADDR, realign_valid_o=0, realign_addr_o=0, realign_data_o=0, realign_flush_o=0; outstanding=0, drop_cnt=0, credits=CREDITS.
- First request: req_valid_o=1 two cycles after rst_i deasserts (BOOT then RUN).
- Response to re-aligner: combinational, 0 cycles.
- Redirect: first request to redirect_addr_i in the cycle after flush_i.
- Back-to-back: one request per cycle while credits and outstanding allow; response freeing a slot enables next request one cycle later.
- rst_i mid-operation: all state cleared immediately; in-flight responses after reset are ignored as outstanding=0.

## Test plan
- Reset, req_ready_i=1, responses 1 cycle later, credits returned each cycle -> req_addr_o 8000_0000, 8000_0004, 8000_0008...; realign_addr_o matches in order.
- credit_return_i=0, CREDITS=4 -> exactly 4 handshakes then req_valid_o=0; one credit_return_i pulse -> one more request next cycle.
- Two requests outstanding, flush_i with redirect 0000_1002 -> next two responses dropped (realign_valid_o=0), credits restored by 2, next request address 0000_1002 then 0000_1004.
- flush_i in same cycle as resp_valid_i, outstanding=1 -> response dropped, drop_cnt=0, realign_flush_o=1.
- req_ready_i=0 for 3 cycles -> req_valid_o and req_addr_o stable; halt_i=1 during wait -> HALTED only after handshake.
- FETCH_WIDTH=64, redirect to ...0006 -> requests ...0006, ...0008, ...0010.
